// File: rtl/gcd_job_sequencer.sv
// Transactional front end for the rv32i GCD core: reset, start, run, then return result or timeout.
// Optional GCD_STATS_EN adds job, timeout and last-run-length counters.
module gcd_job_sequencer #(
  parameter int RESET_CYCLES   = 2,
  parameter int START_CYCLES   = 6,
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_timeout,
  output logic             cpu_rst_n,
  output logic             cpu_calc_start,
  output logic [31:0]      cpu_gcd_a,
  output logic [31:0]      cpu_gcd_b,
  input  logic [31:0]      cpu_gcd_result
`ifdef GCD_STATS_EN
  ,
  output logic [31:0]      stat_jobs,
  output logic [31:0]      stat_timeouts,
  output logic [CNT_W-1:0] stat_last_cycles
`endif
);

  localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  START_N   = CNT_W'(START_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [STAB_W-1:0]  r_stab;
  logic [STAB_W-1:0]  w_stab_next;
  logic [31:0]        r_prev;

  logic               r_req_ready;
  logic               r_rsp_valid;
  logic [31:0]        r_rsp_result;
  logic               r_rsp_timeout;
  logic               r_cpu_rst_n;
  logic               r_cpu_calc_start;
  logic [31:0]        r_cpu_gcd_a;
  logic [31:0]        r_cpu_gcd_b;

  logic               w_req_ready_next;
  logic               w_rsp_valid_next;
  logic [31:0]        w_rsp_result_next;
  logic               w_rsp_timeout_next;
  logic               w_cpu_rst_n_next;
  logic               w_cpu_calc_start_next;
  logic [31:0]        w_cpu_gcd_a_next;
  logic [31:0]        w_cpu_gcd_b_next;

  logic               w_accept;
  logic               w_bypass;
  logic               w_match;
  logic               w_complete;
  logic               w_timeout;
  logic               w_rsp_hs;

  assign w_accept   = (r_state == S_IDLE) && req_valid && r_req_ready;
  assign w_bypass   = (req_a == 32'd0) || (req_b == 32'd0);
  assign w_match    = (cpu_gcd_result != 32'd0) && (cpu_gcd_result == r_prev);
  assign w_complete = (r_state == S_RUN) && w_match && (r_stab == STAB_LAST);
  // Completion takes priority over a coincident timeout.
  assign w_timeout  = (r_state == S_RUN) && !w_complete && (r_cnt == TO_LAST);
  assign w_rsp_hs   = r_rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_stab  <= '0;
      r_prev  <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_stab  <= w_stab_next;
      r_prev  <= (r_state == S_RUN) ? cpu_gcd_result : 32'd0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = w_bypass ? S_DONE : S_RST;
      S_RST:  if (r_cnt == RST_LAST) w_state_next = S_RUN;
      S_RUN:  if (w_complete || w_timeout) w_state_next = S_DONE;
      S_DONE: if (w_rsp_hs) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_next  = '0;
    w_stab_next = '0;
    if (w_state_next == r_state && (r_state == S_RST || r_state == S_RUN)) begin
      w_cnt_next = r_cnt + 1'b1;
    end
    if (r_state == S_RUN && w_state_next == S_RUN && w_match) begin
      w_stab_next = r_stab + 1'b1;
    end
  end

  always_comb begin
    w_req_ready_next      = (w_state_next == S_IDLE);
    w_rsp_valid_next      = (w_state_next == S_DONE);
    w_cpu_rst_n_next      = (w_state_next == S_RUN);
    w_cpu_calc_start_next = (w_state_next == S_RUN) && (w_cnt_next < START_N);
    w_rsp_result_next     = r_rsp_result;
    w_rsp_timeout_next    = r_rsp_timeout;
    w_cpu_gcd_a_next      = r_cpu_gcd_a;
    w_cpu_gcd_b_next      = r_cpu_gcd_b;
    if (w_accept) begin
      w_cpu_gcd_a_next = req_a;
      w_cpu_gcd_b_next = req_b;
      if (w_bypass) begin
        w_rsp_result_next  = req_a | req_b;
        w_rsp_timeout_next = 1'b0;
      end
    end
    if (w_complete) begin
      w_rsp_result_next  = cpu_gcd_result;
      w_rsp_timeout_next = 1'b0;
    end else if (w_timeout) begin
      w_rsp_result_next  = 32'd0;
      w_rsp_timeout_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready      <= 1'b0;
      r_rsp_valid      <= 1'b0;
      r_rsp_result     <= 32'd0;
      r_rsp_timeout    <= 1'b0;
      r_cpu_rst_n      <= 1'b0;
      r_cpu_calc_start <= 1'b0;
      r_cpu_gcd_a      <= 32'd0;
      r_cpu_gcd_b      <= 32'd0;
    end else begin
      r_req_ready      <= w_req_ready_next;
      r_rsp_valid      <= w_rsp_valid_next;
      r_rsp_result     <= w_rsp_result_next;
      r_rsp_timeout    <= w_rsp_timeout_next;
      r_cpu_rst_n      <= w_cpu_rst_n_next;
      r_cpu_calc_start <= w_cpu_calc_start_next;
      r_cpu_gcd_a      <= w_cpu_gcd_a_next;
      r_cpu_gcd_b      <= w_cpu_gcd_b_next;
    end
  end

  assign req_ready      = r_req_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_result     = r_rsp_result;
  assign rsp_timeout    = r_rsp_timeout;
  assign cpu_rst_n      = r_cpu_rst_n;
  assign cpu_calc_start = r_cpu_calc_start;
  assign cpu_gcd_a      = r_cpu_gcd_a;
  assign cpu_gcd_b      = r_cpu_gcd_b;

`ifdef GCD_STATS_EN
  logic [31:0]      r_stat_jobs;
  logic [31:0]      r_stat_timeouts;
  logic [CNT_W-1:0] r_stat_last_cycles;
  logic             w_done_entry;

  assign w_done_entry = (r_state != S_DONE) && (w_state_next == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_jobs        <= 32'd0;
      r_stat_timeouts    <= 32'd0;
      r_stat_last_cycles <= '0;
    end else begin
      if (w_rsp_hs) begin
        r_stat_jobs <= r_stat_jobs + 32'd1;
        if (r_rsp_timeout) r_stat_timeouts <= r_stat_timeouts + 32'd1;
      end
      // RUN length includes the exit cycle; bypass jobs never enter RUN.
      if (w_done_entry) begin
        r_stat_last_cycles <= (r_state == S_RUN) ? r_cnt + 1'b1 : '0;
      end
    end
  end

  assign stat_jobs        = r_stat_jobs;
  assign stat_timeouts    = r_stat_timeouts;
  assign stat_last_cycles = r_stat_last_cycles;
`endif

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Randomized bench for gcd_job_sequencer with a behavioural CPU stub and a job-level reference model.
module tb_gcd_job_sequencer;
  localparam int RC = 2;
  localparam int SC = 6;
  localparam int STC = 2;
  localparam int TO = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_a = 32'd0;
  logic [31:0]   req_b = 32'd0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_result;
  logic          rsp_timeout;
  logic          cpu_rst_n;
  logic          cpu_calc_start;
  logic [31:0]   cpu_gcd_a;
  logic [31:0]   cpu_gcd_b;
  logic [31:0]   cpu_gcd_result;
`ifdef GCD_STATS_EN
  logic [31:0]   stat_jobs;
  logic [31:0]   stat_timeouts;
  logic [CW-1:0] stat_last_cycles;
  int            exp_jobs = 0;
  int            exp_tos = 0;
`endif

  int chk_total = 0;
  int chk_bad = 0;

  gcd_job_sequencer #(
    .RESET_CYCLES(RC), .START_CYCLES(SC), .STABLE_CYCLES(STC),
    .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_timeout(rsp_timeout),
    .cpu_rst_n(cpu_rst_n), .cpu_calc_start(cpu_calc_start),
    .cpu_gcd_a(cpu_gcd_a), .cpu_gcd_b(cpu_gcd_b), .cpu_gcd_result(cpu_gcd_result)
`ifdef GCD_STATS_EN
    ,
    .stat_jobs(stat_jobs), .stat_timeouts(stat_timeouts),
    .stat_last_cycles(stat_last_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] t;
    x = a;
    y = b;
    for (int i = 0; i < 64 && y != 32'd0; i++) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // CPU stub: zero until cycle L of the run, one glitch value, then the settled GCD.
  int          rk = 0;
  int          stub_l = 10;
  bit          stub_stuck = 1'b0;
  logic [31:0] stub_g;
  assign stub_g = ref_gcd(cpu_gcd_a, cpu_gcd_b);
  assign cpu_gcd_result = (!cpu_rst_n || stub_stuck || rk < stub_l) ? 32'd0 :
                          (rk == stub_l) ? stub_g + 32'd1 : stub_g;
  always @(posedge clk) rk <= cpu_rst_n ? rk + 1 : 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_total++;
    if (got !== exp) begin
      chk_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic run_job(input logic [31:0] a, input logic [31:0] b, input int l,
                         input bit stuck, input int hold);
    bit          bypass;
    bit          exp_to;
    int          run;
    int          exp_lat;
    logic [31:0] exp_res;
    int          n;
    int          first_hi;
    int          calc_cnt;
    bit          calc_at_rise;
    bit          ab_ok;

    stub_l = l;
    stub_stuck = stuck;
    bypass = (a == 32'd0) || (b == 32'd0);
    if (bypass) begin
      exp_res = a | b;
      exp_to = 1'b0;
      run = 0;
      exp_lat = 1;
    end else begin
      // Settled value first seen at run cycle l+1; STC further matching samples complete.
      if (!stuck && (l + 1 + STC) <= TO - 1) begin
        exp_res = ref_gcd(a, b);
        exp_to = 1'b0;
        run = l + 1 + STC + 1;
      end else begin
        exp_res = 32'd0;
        exp_to = 1'b1;
        run = TO;
      end
      exp_lat = RC + run + 1;
    end

    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("req_ready_idle", 32'(req_ready), 32'd1);
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_a = $urandom;
    req_b = $urandom;

    n = 1;
    first_hi = 0;
    calc_cnt = 0;
    calc_at_rise = 1'b0;
    ab_ok = 1'b1;
    while (n <= 200) begin
      if (cpu_calc_start) calc_cnt++;
      if (cpu_rst_n && first_hi == 0) begin
        first_hi = n;
        calc_at_rise = cpu_calc_start;
      end
      if (cpu_gcd_a !== a || cpu_gcd_b !== b) ab_ok = 1'b0;
      if (rsp_valid) break;
      @(negedge clk);
      n++;
    end
    check_val("rsp_latency", 32'(n), 32'(exp_lat));
    check_val("rsp_result", rsp_result, exp_res);
    check_val("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
    check_val("cpu_operands", 32'(ab_ok), 32'd1);
    if (bypass) begin
      check_val("bypass_no_rst_rise", 32'(first_hi), 32'd0);
    end else begin
      check_val("rst_low_cycles", 32'(first_hi), 32'(RC + 1));
      check_val("start_with_rise", 32'(calc_at_rise), 32'd1);
      check_val("start_cycles", 32'(calc_cnt), 32'(SC));
    end

    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      @(negedge clk);
      check_val("hold_valid", 32'(rsp_valid), 32'd1);
      check_val("hold_result", rsp_result, exp_res);
      check_val("hold_ready_low", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_val("valid_drop", 32'(rsp_valid), 32'd0);
    check_val("ready_back", 32'(req_ready), 32'd1);
`ifdef GCD_STATS_EN
    exp_jobs++;
    if (exp_to) exp_tos++;
    check_val("stat_jobs", stat_jobs, 32'(exp_jobs));
    check_val("stat_timeouts", stat_timeouts, 32'(exp_tos));
    check_val("stat_last_cycles", 32'(stat_last_cycles), 32'(run));
`endif
    $display("job a=%0d b=%0d l=%0d stuck=%0d hold=%0d -> result=%0d timeout=%0d lat=%0d",
             a, b, l, stuck, hold, rsp_result, rsp_timeout, n);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;

    @(negedge clk);
    check_val("rst_req_ready", 32'(req_ready), 32'd0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_rsp_result", rsp_result, 32'd0);
    check_val("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check_val("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check_val("rst_calc_start", 32'(cpu_calc_start), 32'd0);
    check_val("rst_gcd_a", cpu_gcd_a, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_ready", 32'(req_ready), 32'd1);

    run_job(32'd15, 32'd10, 8, 1'b0, 0);
    run_job(32'd0, 32'd7, 8, 1'b0, 0);
    run_job(32'd9, 32'd0, 8, 1'b0, 0);
    run_job(32'd0, 32'd0, 8, 1'b0, 0);
    run_job(32'd8, 32'd12, 8, 1'b1, 0);
    run_job(32'd21, 32'd14, 12, 1'b0, 20);
    run_job(32'd48, 32'd18, 6, 1'b0, 0);
    run_job(32'd100, 32'd75, TO - STC - 2, 1'b0, 0);
    run_job(32'd100, 32'd75, TO - STC - 1, 1'b0, 0);

    // Reset in the middle of a run.
    stub_l = 20;
    stub_stuck = 1'b0;
    req_a = 32'd15;
    req_b = 32'd10;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check_val("mid_run_rst_n_high", 32'(cpu_rst_n), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("async_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check_val("async_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("async_calc_start", 32'(cpu_calc_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef GCD_STATS_EN
    exp_jobs = 0;
    exp_tos = 0;
`endif
    @(negedge clk);
    check_val("rerst_ready", 32'(req_ready), 32'd1);
    check_val("rerst_valid", 32'(rsp_valid), 32'd0);
    run_job(32'd12, 32'd8, 5, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 999));
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 999));
      run_job(ra, rb, $urandom_range(2, 70), ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", chk_total, chk_bad);
    $finish;
  end
endmodule
